nios2os_avalon_st_error_tagger: RTL and testbench

NIOS2OS_AVALON_ST_ERROR_TAGGER -- requirements
Module: nios2os_avalon_st_error_tagger

---
 rtl/nios2os_avalon_st_error_tagger.sv | 123 ++++++++++++
 tb/tb_nios2os_avalon_st_error_tagger.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2os_avalon_st_error_tagger.sv
// rtl/nios2os_avalon_st_error_tagger.sv - Avalon-ST framing checker that tags packets with error bits
//
// Purpose: single output register stage between an Avalon-ST sink (no error)
// and an Avalon-ST source (with 6-bit error). Each beat is copied unchanged and
// tagged with sticky per-packet framing/length errors:
//   bit0 orphan (non-sop beat outside a packet), bit1 missing eop,
//   bit2 oversize, bit3 undersize, bit4 nonzero empty on a non-eop beat, bit5 = 0.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_startofpacket/in_endofpacket/in_empty   sink
//   out_valid/out_ready/out_data/out_startofpacket/out_endofpacket/
//   out_empty/out_error                                                   source
//   err_pkt_count            saturating count of packets ending with nonzero error
module nios2os_avalon_st_error_tagger #(
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned MAX_BYTES = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [1:0]  in_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic [5:0]  out_error,
  output logic [15:0] err_pkt_count
);

  typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

  state_t      state, state_next;
  logic [15:0] byte_count, count_next;
  logic [15:0] pkt_len;
  logic [5:0]  err_acc, err_base, err_next;
  logic        accept;
  logic        eff_sop, orphan, missing_eop;
  logic        oversize, undersize, bad_empty;

  // Register slice: upstream may push whenever the slot is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next  = state;
    orphan      = (state == IDLE) && !in_startofpacket;
    missing_eop = (state == IN_PKT) && in_startofpacket;
    // An orphan beat opens a packet exactly as a real sop would.
    eff_sop     = in_startofpacket || (state == IDLE);

    if (eff_sop) begin
      count_next = 16'd4;
    end else if (byte_count > 16'hFFFB) begin
      count_next = 16'hFFFF;
    end else begin
      count_next = byte_count + 16'd4;
    end

    // count_next is at least 4 and in_empty at most 3, so no underflow.
    pkt_len   = count_next - {14'd0, in_empty};
    oversize  = ({16'd0, count_next} > MAX_BYTES);
    undersize = in_endofpacket && ({16'd0, pkt_len} < MIN_BYTES);
    bad_empty = !in_endofpacket && (in_empty != 2'd0);

    err_base = eff_sop ? 6'd0 : err_acc;
    err_next = err_base | {1'b0, bad_empty, undersize, oversize, missing_eop, orphan};

    if (accept) begin
      state_next = in_endofpacket ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_count <= 16'd0;
      err_acc    <= 6'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        byte_count <= count_next;
        err_acc    <= err_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= 32'd0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= 2'd0;
      out_error         <= 6'd0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_data          <= in_data;
      out_startofpacket <= in_startofpacket;
      out_endofpacket   <= in_endofpacket;
      out_empty         <= in_empty;
      out_error         <= err_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pkt_count <= 16'd0;
    end else if (accept && in_endofpacket && (err_next != 6'd0)
                 && (err_pkt_count != 16'hFFFF)) begin
      err_pkt_count <= err_pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_nios2os_avalon_st_error_tagger.sv
// tb/tb_nios2os_avalon_st_error_tagger.sv - directed self-checking bench for the error tagger
module tb_nios2os_avalon_st_error_tagger;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [1:0]  in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic [5:0]  out_error;
  logic [15:0] err_pkt_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [5:0]  err;
  } beat_t;

  beat_t q[$];
  bit    done;

  always #5 clk = ~clk;

  nios2os_avalon_st_error_tagger #(.MIN_BYTES(64), .MAX_BYTES(1518)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .out_error         (out_error),
    .err_pkt_count     (err_pkt_count)
  );

  // Beats leaving the source; out_ready only changes just after posedge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q.push_back('{data: out_data, sop: out_startofpacket, eop: out_endofpacket,
                    empty: out_empty, err: out_error});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] emp);
    int waited;
    in_data          = d;
    in_startofpacket = s;
    in_endofpacket   = e;
    in_empty         = emp;
    in_valid         = 1'b1;
    waited           = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit with_eop,
                          input logic [1:0] last_empty);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 32'(i), i == 0, with_eop && (i == n - 1),
                (i == n - 1) ? last_empty : 2'd0);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n          = 1'b0;
    in_valid         = 1'b0;
    in_data          = 32'd0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_empty         = 2'd0;
    out_ready        = 1'b1;
    done             = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_error", 32'(out_error), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_count", 32'(err_pkt_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 16-beat 64-byte packet: clean, 1-cycle latency
    q.delete();
    send_beat(32'h1000_0000, 1'b1, 1'b0, 2'd0);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_data", out_data, 32'h1000_0000);
    for (int i = 1; i < 16; i++) send_beat(32'h1000_0000 + 32'(i), 1'b0, i == 15, 2'd0);
    drain();
    check("p16_beats", 32'(q.size()), 32'd16);
    foreach (q[i]) begin
      check("p16_data", q[i].data, 32'h1000_0000 + 32'(i));
      check("p16_err", 32'(q[i].err), 32'd0);
    end
    check("p16_sop", 32'(q[0].sop), 32'd1);
    check("p16_eop", 32'(q[15].eop), 32'd1);
    check("p16_count", 32'(err_pkt_count), 32'd0);

    // 63 bytes: undersize only on eop beat
    q.delete();
    send_pkt(16, 32'h2000_0000, 1'b1, 2'd1);
    drain();
    check("p63_beats", 32'(q.size()), 32'd16);
    foreach (q[i]) check("p63_err", 32'(q[i].err), (i == 15) ? 32'h08 : 32'h00);
    check("p63_count", 32'(err_pkt_count), 32'd1);

    // Single 2-byte beat
    q.delete();
    send_beat(32'hABCD_0002, 1'b1, 1'b1, 2'd2);
    drain();
    check("one_beats", 32'(q.size()), 32'd1);
    check("one_err", 32'(q[0].err), 32'h08);
    check("one_empty", 32'(q[0].empty), 32'd2);
    check("one_count", 32'(err_pkt_count), 32'd2);

    // 400 beats, 1600 bytes: oversize from beat 380 (1520 bytes) onward
    q.delete();
    send_pkt(400, 32'h3000_0000, 1'b1, 2'd0);
    drain();
    check("big_beats", 32'(q.size()), 32'd400);
    foreach (q[i]) check($sformatf("big_err_%0d", i + 1), 32'(q[i].err),
                         (i >= 379) ? 32'h04 : 32'h00);
    check("big_count", 32'(err_pkt_count), 32'd3);

    // Packet A (sop + 20, no eop) then packet B (20 beats with eop)
    q.delete();
    send_pkt(21, 32'h4000_0000, 1'b0, 2'd0);
    send_pkt(20, 32'h5000_0000, 1'b1, 2'd0);
    drain();
    check("ab_beats", 32'(q.size()), 32'd41);
    foreach (q[i]) check("ab_err", 32'(q[i].err), (i < 21) ? 32'h00 : 32'h02);
    check("ab_b_sop", 32'(q[21].sop), 32'd1);
    check("ab_count", 32'(err_pkt_count), 32'd4);

    // Backpressure 1,0,0,1 during a 16-beat packet
    q.delete();
    done = 1'b0;
    fork
      begin
        send_pkt(16, 32'h6000_0000, 1'b1, 2'd0);
        done = 1'b1;
      end
      begin
        int k;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        while (!done && k < 1000) begin
          out_ready = pat[3 - (k % 4)];
          k++;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        logic held;
        beat_t h;
        held = 1'b0;
        h = '{default: '0};
        while (!done) begin
          @(negedge clk);
          if (held) begin
            check("hold_data", out_data, h.data);
            check("hold_err", 32'(out_error), 32'(h.err));
            check("hold_eop", 32'(out_endofpacket), 32'(h.eop));
            check("hold_valid", 32'(out_valid), 32'd1);
          end
          check("stall_in_ready", 32'(in_ready), (out_valid && !out_ready) ? 32'd0 : 32'd1);
          held   = out_valid && !out_ready;
          h.data = out_data;
          h.err  = out_error;
          h.eop  = out_endofpacket;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_beats", 32'(q.size()), 32'd16);
    foreach (q[i]) begin
      check("bp_data", q[i].data, 32'h6000_0000 + 32'(i));
      check("bp_err", 32'(q[i].err), 32'd0);
    end
    check("bp_count", 32'(err_pkt_count), 32'd4);

    // Reset at beat 5 of a packet, then a non-sop beat
    send_pkt(5, 32'h7000_0000, 1'b0, 2'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_error", 32'(out_error), 32'd0);
    check("mid_rst_count", 32'(err_pkt_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    q.delete();
    send_beat(32'h8000_0001, 1'b0, 1'b0, 2'd0);
    send_beat(32'h8000_0002, 1'b0, 1'b1, 2'd0);
    drain();
    check("orphan_beats", 32'(q.size()), 32'd2);
    check("orphan_err0", 32'(q[0].err), 32'h01);
    check("orphan_data0", q[0].data, 32'h8000_0001);
    check("orphan_err1", 32'(q[1].err), 32'h09);
    check("orphan_count", 32'(err_pkt_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
